// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encoding, lamp struct and per-head lamp decode for intersection_sequencer.
package traffic_pkg;
  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR_1 = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR_2 = 3'd5
  } phase_e;
  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;
  function automatic lamp_t lamp_of(input phase_e p, input logic ns);
    phase_e g, y;
    g = ns ? NS_G : EW_G;
    y = ns ? NS_Y : EW_Y;
    return '{red: p != g && p != y, yellow: p == y, green: p == g};
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating phase counter with sync clear; done once dur cycles have elapsed.
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [TW-1:0] dur,
  output logic [TW-1:0] count,
  output logic          done
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (count != '1) count <= count + TW'(1);
  assign done = count >= dur - TW'(1);
endmodule

// File: rtl/intersection_sequencer.sv
// intersection_sequencer: demand-actuated two-head signal sequencer with preemption.
// Optional pedestrian walk phases are built when PED_WALK_EN is defined.
module intersection_sequencer
  import traffic_pkg::*;
#(
`ifdef PED_WALK_EN
  parameter int W_TIME  = 3,
`endif
  parameter int TW      = 8,
  parameter int G_MIN   = 4,
  parameter int G_MAX   = 10,
  parameter int Y_TIME  = 3,
  parameter int AR_TIME = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       preempt,
`ifdef PED_WALK_EN
  input  logic       ped_ns,
  input  logic       ped_ew,
  output logic       walk_ns,
  output logic       walk_ew,
`endif
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic [2:0] phase
);
  phase_e state, next;
  logic [TW-1:0] count, dur;
  logic done, clr, green, yellow, all_red, go, gap, walk_hold;
  logic dem_ns, dem_ew, req_ns, req_ew, ns_entry, ew_entry;
  lamp_t ns_l, ew_l;
  assign green   = state == NS_G || state == EW_G;
  assign yellow  = state == NS_Y || state == EW_Y;
  assign all_red = state == AR_1 || state == AR_2;
  assign dur = green ? TW'(G_MAX) : yellow ? TW'(Y_TIME) : TW'(AR_TIME);
  assign gap = (state == NS_G ? dem_ew && !car_ns : dem_ns && !car_ew)
               && count >= TW'(G_MIN - 1) && !walk_hold;
  always_comb begin
    go = green ? preempt || gap || (state == NS_G ? dem_ew : dem_ns) && done
       : all_red ? !preempt && done : done;
    next = !go ? state : state == AR_2 ? NS_G : phase_e'(state + 3'd1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= AR_2;
    else state <= next;
  // Preempt keeps the all-red timer cleared so clearance restarts when it falls.
  assign clr = next != state || (all_red && preempt);
  phase_timer #(.TW(TW)) u_timer (
    .clk(clk), .rst(rst), .clr(clr), .dur(dur), .count(count), .done(done)
  );
  assign ns_entry = next == NS_G && state != NS_G;
  assign ew_entry = next == EW_G && state != EW_G;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dem_ns <= 1'b0;
      dem_ew <= 1'b0;
    end else begin
      dem_ns <= !ns_entry && (dem_ns || req_ns);
      dem_ew <= !ew_entry && (dem_ew || req_ew);
    end
`ifdef PED_WALK_EN
  logic ped_dem_ns, ped_dem_ew, walk_on;
  assign req_ns = car_ns || ped_ns;
  assign req_ew = car_ew || ped_ew;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ped_dem_ns <= 1'b0;
      ped_dem_ew <= 1'b0;
      walk_on    <= 1'b0;
    end else begin
      ped_dem_ns <= !ns_entry && (ped_dem_ns || ped_ns);
      ped_dem_ew <= !ew_entry && (ped_dem_ew || ped_ew);
      walk_on    <= (ns_entry && (ped_dem_ns || ped_ns)) || (ew_entry && (ped_dem_ew || ped_ew))
                    || (walk_on && !preempt && next == state);
    end
  assign walk_hold = walk_on && !preempt && count < TW'(W_TIME);
  assign walk_ns = walk_hold && state == NS_G;
  assign walk_ew = walk_hold && state == EW_G;
`else
  assign req_ns = car_ns;
  assign req_ew = car_ew;
  assign walk_hold = 1'b0;
`endif
  assign ns_l = lamp_of(state, 1'b1);
  assign ew_l = lamp_of(state, 1'b0);
  assign {ns_red, ns_yellow, ns_green} = ns_l;
  assign {ew_red, ew_yellow, ew_green} = ew_l;
  assign phase = state;
endmodule

// File: tb/tb_intersection_sequencer.sv
// tb_intersection_sequencer: directed checks of phase sequencing, demand, gap/max-out, preempt and reset.
module tb_intersection_sequencer;
  localparam logic [2:0] NSG = 3'd0, NSY = 3'd1, AR1 = 3'd2, EWG = 3'd3, EWY = 3'd4, AR2 = 3'd5;
  logic clk, rst, car_ns, car_ew, preempt;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic [2:0] phase;
  int tests = 0, fails = 0;
`ifdef PED_WALK_EN
  logic ped_ns, ped_ew, walk_ns, walk_ew;
`endif
  intersection_sequencer dut (
    .clk(clk), .rst(rst), .car_ns(car_ns), .car_ew(car_ew), .preempt(preempt),
`ifdef PED_WALK_EN
    .ped_ns(ped_ns), .ped_ew(ped_ew), .walk_ns(walk_ns), .walk_ew(walk_ew),
`endif
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green), .phase(phase)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [8:0] view(input logic [2:0] p);
    logic [2:0] ns, ew;
    ns = p == 3'd0 ? 3'b001 : p == 3'd1 ? 3'b010 : 3'b100;
    ew = p == 3'd3 ? 3'b001 : p == 3'd4 ? 3'b010 : 3'b100;
    return {p, ns, ew};
  endfunction
  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic ph(input string tag, input logic [2:0] p);
    chk(tag, {phase, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}, view(p));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; car_ns = 1'b0; car_ew = 1'b0; preempt = 1'b0;
`ifdef PED_WALK_EN
    ped_ns = 1'b0; ped_ew = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    ph("reset_state", AR2);
    rst = 1'b0;
    ph("rest_ar_c1", AR2); tick();
    ph("rest_ar_c2", AR2); tick();
    for (int i = 0; i < 8; i++) begin ph("rest_ns_g", NSG); tick(); end
    repeat (248) tick();
    car_ew = 1'b1; ph("sat_pulse", NSG); tick();
    car_ew = 1'b0; ph("sat_eval", NSG); tick();
    ph("sat_exit", NSY);
    reset_dut();
    repeat (4) tick();
    car_ew = 1'b1; tick();
    car_ew = 1'b0; ph("gap_g4", NSG); tick();
    for (int i = 0; i < 3; i++) begin ph("gap_ns_y", NSY); tick(); end
    for (int i = 0; i < 2; i++) begin ph("gap_ar1", AR1); tick(); end
    for (int i = 0; i < 4; i++) begin ph("gap_ew_rest", EWG); tick(); end
    reset_dut();
    repeat (2) tick();
    car_ns = 1'b1; car_ew = 1'b1;
    for (int i = 0; i < 10; i++) begin ph("max_ns_g", NSG); tick(); car_ew = 1'b0; end
    ph("max_ns_y", NSY);
    car_ns = 1'b0; tick();
    for (int i = 0; i < 2; i++) begin ph("max_ns_y", NSY); tick(); end
    for (int i = 0; i < 2; i++) begin ph("max_ar1", AR1); tick(); end
    for (int i = 0; i < 4; i++) begin ph("ew_gap_g", EWG); tick(); end
    for (int i = 0; i < 3; i++) begin ph("ew_y", EWY); tick(); end
    for (int i = 0; i < 2; i++) begin ph("ar2", AR2); tick(); end
    for (int i = 0; i < 3; i++) begin ph("ns_rest", NSG); tick(); end
    reset_dut();
    repeat (2) tick();
    preempt = 1'b1; ph("pre_g1", NSG); tick();
    for (int i = 0; i < 3; i++) begin ph("pre_ns_y", NSY); tick(); end
    for (int i = 0; i < 5; i++) begin ph("pre_ar_hold", AR1); tick(); end
    preempt = 1'b0;
    for (int i = 0; i < 2; i++) begin ph("pre_ar_clear", AR1); tick(); end
    ph("pre_ew_g", EWG);
    reset_dut();
    repeat (2) tick();
    preempt = 1'b1; tick();
    preempt = 1'b0; car_ns = 1'b1; car_ew = 1'b1;
    ph("rst_mid_y", NSY); tick();
    car_ns = 1'b0; car_ew = 1'b0; rst = 1'b1; tick();
    ph("rst_applied", AR2);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin ph("rst_ar2", AR2); tick(); end
    for (int i = 0; i < 8; i++) begin ph("rst_dem_clear", NSG); tick(); end
`ifdef PED_WALK_EN
    reset_dut();
    repeat (2) tick();
    ped_ew = 1'b1; ph("ped_ns_g", NSG); tick();
    ped_ew = 1'b0;
    for (int i = 0; i < 3; i++) begin ph("ped_ns_g", NSG); tick(); end
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      ph("ped_ew_g", EWG);
      chk("walk_on", {7'd0, walk_ns, walk_ew}, 9'd1);
      tick();
    end
    chk("walk_off", {7'd0, walk_ns, walk_ew}, 9'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
